result_tx: RTL
==============

RESULT_TX -- requirements
Module: result_tx

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 4: number of result elements per transfer.
REQ-002 SHALL have parameter ELEM_W, default 8: width of each element in bits.
REQ-003 SHALL have parameter GAP_CYCLES, default 2: idle cycles inserted between consecutive elements (0 allowed).
REQ-004 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port result_ready, input, 1: single-cycle pulse from the input FSM; result_data is valid in the same cycle.
REQ-007 SHALL have port result_data, input, NUM_ELEM*ELEM_W: packed result; element k at bits [k*ELEM_W +: ELEM_W].
REQ-008 SHALL have port elem_ready, input, 1: display sink accepts the current element.
REQ-009 SHALL have port elem_valid, output, 1: element presented to the sink.
REQ-010 SHALL have port elem_data, output, ELEM_W: element value, or magnitude when signed mode is compiled in.
REQ-011 SHALL have port elem_idx, output, clog2(NUM_ELEM): index of the element presented.
REQ-012 SHALL have port elem_neg, output, 1: sign flag of the presented element.
REQ-013 SHALL have port busy, output, 1: transfer in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse after the last element is accepted.
REQ-015 SHALL have port overrun, output, 1: sticky flag, set when a result_ready pulse is dropped.

Function
REQ-016 SHALL implement states IDLE, SEND, GAP and DONE.
REQ-017 SHALL, in IDLE or DONE with result_ready=1, capture result_data into a shadow register, set idx to 0, clear overrun and go to SEND on the next cycle.
REQ-018 SHALL, in SEND, drive elem_valid=1 and hold elem_data, elem_idx and elem_neg stable from shadow[idx] until the handshake completes.
REQ-019 SHALL complete the handshake on a rising edge where elem_valid=1 and elem_ready=1; elem_ready while elem_valid=0 has no effect.
REQ-020 SHALL, on handshake with idx<NUM_ELEM-1, go to GAP with a counter loaded to GAP_CYCLES; when GAP_CYCLES=0, go directly to SEND with idx+1.
REQ-021 SHALL, in GAP, drive elem_valid=0, decrement the counter each cycle and enter SEND with idx+1 after exactly GAP_CYCLES cycles.
REQ-022 SHALL, on handshake with idx=NUM_ELEM-1, go to DONE; DONE asserts done=1 for exactly one cycle, then goes to IDLE unless REQ-017 applies.
REQ-023 SHALL assert busy=1 in SEND and GAP, and busy=0 in IDLE and DONE.
REQ-024 SHALL ignore result_ready in SEND or GAP, leaving the shadow register unchanged and setting overrun=1.
REQ-025 SHALL produce first elem_valid 1 cycle after result_ready, with elem_ready tied high; one element is accepted every GAP_CYCLES+1 cycles.
REQ-026 SHALL drive elem_data, elem_idx and elem_neg to 0 whenever elem_valid=0.

Reset
REQ-027 SHALL, on nrst=0, immediately force state IDLE, idx 0, gap counter 0, shadow register 0, and all outputs 0.
REQ-028 SHALL abort a transfer when reset is asserted mid-operation; no done pulse is produced and no partial state is retained after release.
REQ-029 SHALL start in IDLE on the first clock edge after nrst rises; result_ready on that edge is captured.

Configuration
REQ-030 SHALL, when RESULT_TX_SIGNED_EN is defined, treat elements as two's complement: elem_neg=MSB and elem_data=magnitude.
REQ-031 SHALL, with RESULT_TX_SIGNED_EN defined, map the most negative value (0x80 for ELEM_W=8) to elem_neg=1, elem_data=0x80.
REQ-032 SHALL, when RESULT_TX_SIGNED_EN is undefined, pass elements through raw with elem_neg tied to 0.

Verification
REQ-033 SHALL verify the basic transfer: result_data=0x04030201 pulse, elem_ready=1, GAP_CYCLES=2 -> elem_data 01,02,03,04 with idx 0..3 on cycles 1,4,7,10 after the pulse, then done one cycle after the last handshake, busy low afterwards.
REQ-034 SHALL verify backpressure: elem_ready=0 for 5 cycles on element 1 -> elem_valid, elem_data and elem_idx stay stable, and no index advance occurs.
REQ-035 SHALL verify overrun: a second result_ready during GAP -> overrun=1, all four original elements are delivered unchanged, and overrun clears on the next accepted capture.
REQ-036 SHALL verify signed mode: RESULT_TX_SIGNED_EN defined with elements 0xFF, 0x80, 0x7F, 0x00 -> (neg,data) = (1,01), (1,80), (0,7F), (0,00); with the macro undefined -> raw values with neg=0.
REQ-037 SHALL verify reset abort: nrst asserted during SEND of idx 2 -> outputs 0 immediately, no done pulse, and a fresh pulse after release restarts at idx 0.
REQ-038 SHALL verify back-to-back results: result_ready in the DONE cycle -> done pulses and the new transfer starts with elem_valid on the next cycle, overrun=0.

Source files
------------

// File: rtl/result_tx.sv
// Result transmitter: captures a packed result and hands its elements to a display
// sink one at a time, inserting idle gaps between them. Define RESULT_TX_SIGNED_EN for sign/magnitude output.
module result_tx #(
  parameter int NUM_ELEM   = 4,
  parameter int ELEM_W     = 8,
  parameter int GAP_CYCLES = 2,
  localparam int IDX_W     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       result_ready,
  input  logic [NUM_ELEM*ELEM_W-1:0] result_data,
  input  logic                       elem_ready,
  output logic                       elem_valid,
  output logic [ELEM_W-1:0]          elem_data,
  output logic [IDX_W-1:0]           elem_idx,
  output logic                       elem_neg,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t                     state, state_next;
  logic [IDX_W-1:0]           idx;
  logic [CNT_W-1:0]           cnt;
  logic [NUM_ELEM*ELEM_W-1:0] shadow;
  logic                       ovr;
  logic                       accept;
  logic                       last;
  logic [ELEM_W-1:0]          cur;

  assign accept = ((state == IDLE) || (state == DONE)) && result_ready;
  assign last   = (idx == LAST_IDX);
  assign cur    = shadow[idx*ELEM_W +: ELEM_W];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: state_next = result_ready ? SEND : IDLE;
      SEND: begin
        if (elem_ready) begin
          if (last)                 state_next = DONE;
          else if (GAP_CYCLES == 0) state_next = SEND;
          else                      state_next = GAP;
        end
      end
      GAP:     state_next = (cnt == CNT_W'(1)) ? SEND : GAP;
      default: state_next = IDLE;
    endcase
  end

  // idx advances on entry to SEND, so it always names the element being presented
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx    <= '0;
      cnt    <= '0;
      shadow <= '0;
      ovr    <= 1'b0;
    end else begin
      if (accept) begin
        shadow <= result_data;
        idx    <= '0;
        cnt    <= '0;
        ovr    <= 1'b0;
      end
      if (((state == SEND) || (state == GAP)) && result_ready) ovr <= 1'b1;
      if ((state == SEND) && elem_ready && !last) begin
        cnt <= GAP_LOAD;
        if (GAP_CYCLES == 0) idx <= idx + IDX_W'(1);
      end
      if (state == GAP) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) idx <= idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    elem_valid = 1'b0;
    elem_data  = '0;
    elem_idx   = '0;
    elem_neg   = 1'b0;
    busy       = (state == SEND) || (state == GAP);
    done       = (state == DONE);
    overrun    = ovr;
    if (state == SEND) begin
      elem_valid = 1'b1;
      elem_idx   = idx;
`ifdef RESULT_TX_SIGNED_EN
      // the most negative value negates to itself, giving magnitude 2**(ELEM_W-1)
      elem_neg   = cur[ELEM_W-1];
      elem_data  = cur[ELEM_W-1] ? -cur : cur;
`else
      elem_data  = cur;
`endif
    end
  end

endmodule
